// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
// Port indices double as round-robin pointer values.
package mem_arb_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;

    localparam logic [1:0] LOAD0 = 2'd0;
    localparam logic [1:0] LOAD1 = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arbState_t;

    function automatic logic [1:0] oneHotToIdx(input logic [2:0] oneHot);
        logic [1:0] idx;
        idx = LOAD0;
        if (oneHot[1]) idx = LOAD1;
        if (oneHot[2]) idx = STORE;
        return idx;
    endfunction

    // Pointer wraps 2 -> 0; the unused code 3 also maps back to 0.
    function automatic logic [1:0] nextPtr(input logic [1:0] ptr);
        return (ptr >= STORE) ? LOAD0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Search order is ptr, ptr+1, ptr+2 (mod 3); pointer value 3 behaves as 0.
module rr_pick3 (
    input  logic [2:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [2:0] o_grant,
    output logic       o_valid
);

    always_comb begin
        o_grant = 3'b000;
        o_valid = |i_req;
        case (i_ptr)
            2'd1: begin
                if (i_req[1])      o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
            end
            2'd2: begin
                if (i_req[2])      o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
            end
            default: begin
                if (i_req[0])      o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port memory arbiter: two load stations and one store station share a
// single memory; one transaction in flight, round-robin fairness, WAIT timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] reqAddr0,
    input  logic [DATA_W-1:0] reqAddr1,
    input  logic [DATA_W-1:0] reqAddr2,
    input  logic [2:0]        reqWe,
    input  logic [DATA_W-1:0] reqWdata2,
    input  logic [TAG_W-1:0]  reqTag0,
    input  logic [TAG_W-1:0]  reqTag1,
    input  logic [TAG_W-1:0]  reqTag2,
    output logic [2:0]        grant,
    output logic              memStart,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memOut,
    output logic              respValid,
    output logic [DATA_W-1:0] respData,
    output logic [TAG_W-1:0]  respTag,
    output logic [1:0]        respPort,
    output logic              writeDone,
    output logic              busy,
    output logic              memErr
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    arbState_t         r_state;
    logic [1:0]        r_rrPtr;
    logic [1:0]        r_winner;
    logic [TAG_W-1:0]  r_tag;
    logic [7:0]        r_waitCnt;
    logic [2:0]        r_grant;
    logic              r_memStart;
    logic              r_memWe;
    logic [DATA_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_respValid;
    logic [DATA_W-1:0] r_respData;
    logic [TAG_W-1:0]  r_respTag;
    logic [1:0]        r_respPort;
    logic              r_writeDone;
    logic              r_memErr;

    logic [2:0]        w_pickGrant;
    logic              w_pickValid;
    logic [1:0]        w_pickIdx;
    logic [DATA_W-1:0] w_selAddr;
    logic [TAG_W-1:0]  w_selTag;
    logic              w_selWe;
    logic [DATA_W-1:0] w_selWdata;

    rr_pick3 u_pick (
        .i_req   (req),
        .i_ptr   (r_rrPtr),
        .o_grant (w_pickGrant),
        .o_valid (w_pickValid)
    );

    assign w_pickIdx = oneHotToIdx(w_pickGrant);

    always_comb begin
        w_selAddr = reqAddr0;
        w_selTag  = reqTag0;
        w_selWe   = reqWe[0];
        case (w_pickIdx)
            LOAD1: begin
                w_selAddr = reqAddr1;
                w_selTag  = reqTag1;
                w_selWe   = reqWe[1];
            end
            STORE: begin
                w_selAddr = reqAddr2;
                w_selTag  = reqTag2;
                w_selWe   = reqWe[2];
            end
            default: ;
        endcase
    end

    // Only the store station carries write data; loads drive zero onto the bus.
    assign w_selWdata = (w_pickIdx == STORE && w_selWe) ? reqWdata2 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rrPtr     <= LOAD0;
            r_winner    <= LOAD0;
            r_tag       <= '0;
            r_waitCnt   <= '0;
            r_grant     <= '0;
            r_memStart  <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_respValid <= 1'b0;
            r_respData  <= '0;
            r_respTag   <= '0;
            r_respPort  <= '0;
            r_writeDone <= 1'b0;
            r_memErr    <= 1'b0;
        end else begin
            r_grant     <= '0;
            r_memStart  <= 1'b0;
            r_respValid <= 1'b0;
            r_writeDone <= 1'b0;
            r_memErr    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        r_state    <= ISSUE;
                        r_winner   <= w_pickIdx;
                        r_tag      <= w_selTag;
                        r_grant    <= w_pickGrant;
                        r_memStart <= 1'b1;
                        r_memWe    <= w_selWe;
                        r_memAddr  <= w_selAddr;
                        r_memWdata <= w_selWdata;
                    end
                end
                ISSUE: begin
                    r_state   <= WAIT;
                    r_waitCnt <= '0;
                end
                WAIT: begin
                    // A ready on the last counted cycle still wins over the timeout.
                    if (memReady || r_waitCnt == LAST_WAIT) begin
                        if (!memReady) begin
                            r_memErr   <= 1'b1;
                            r_respPort <= r_winner;
                        end else if (r_memWe) begin
                            r_writeDone <= 1'b1;
                        end else begin
                            r_respValid <= 1'b1;
                            r_respData  <= memOut;
                            r_respTag   <= r_tag;
                            r_respPort  <= r_winner;
                        end
                        r_state    <= IDLE;
                        r_rrPtr    <= nextPtr(r_winner);
                        r_waitCnt  <= '0;
                        r_memWe    <= 1'b0;
                        r_memAddr  <= '0;
                        r_memWdata <= '0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign memStart  = r_memStart;
    assign memWe     = r_memWe;
    assign memAddr   = r_memAddr;
    assign memWdata  = r_memWdata;
    assign respValid = r_respValid;
    assign respData  = r_respData;
    assign respTag   = r_respTag;
    assign respPort  = r_respPort;
    assign writeDone = r_writeDone;
    assign memErr    = r_memErr;
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, max WAIT cycles before abort (range 2..255).
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  3  request per port: [0]=load station A, [1]=load station B, [2]=store station.
REQ-005 reqAddr0/1/2  in  16 each  address per port.
REQ-006 reqWe  in  3  per-port write flag (1=store).
REQ-007 reqWdata2  in  16  store data (port 2 only).
REQ-008 reqTag0/1/2  in  4 each  reservation-station tag per port.
REQ-009 grant  out  3  one-hot, one-cycle acceptance pulse.
REQ-010 memStart, memWe  out  1 each  memory start strobe and write enable.
REQ-011 memAddr, memWdata  out  16 each  memory address and write data.
REQ-012 memReady  in  1  memory completion strobe; memOut  in  16  read data.
REQ-013 respValid  out  1  one-cycle read-result pulse; respData  out  16; respTag  out  4; respPort  out  2.
REQ-014 writeDone  out  1  one-cycle store-complete pulse.
REQ-015 busy  out  1  high when state != IDLE; memErr  out  1  one-cycle timeout pulse.

Function
REQ-016 FSM SHALL have states IDLE, ISSUE, WAIT; one transaction in flight at most.
REQ-017 IDLE: if any req bit is set, pick the winner round-robin starting at pointer rrPtr, latch its addr/we/wdata/tag/port, go to ISSUE; else stay.
REQ-018 grant[winner] SHALL be 1 for exactly the ISSUE cycle; other grant bits 0.
REQ-019 Requesters hold req/addr/data until grant and drop req the cycle after; req is not sampled in ISSUE or WAIT.
REQ-020 ISSUE: memStart=1 for exactly one cycle with latched memAddr/memWe/memWdata (memWdata=0 for loads); then go to WAIT.
REQ-021 memAddr/memWe/memWdata SHALL hold latched values through WAIT; they are 0 in IDLE.
REQ-022 memReady SHALL be sampled only in WAIT; in IDLE and ISSUE it is ignored.
REQ-023 WAIT + memReady, load: next cycle respValid=1, respData=memOut captured at that edge, respTag/respPort=latched; go to IDLE.
REQ-024 WAIT + memReady, store: next cycle writeDone=1, respValid=0; go to IDLE.
REQ-025 On completion rrPtr SHALL become (winner+1) mod 3; otherwise unchanged.
REQ-026 WAIT counter starts at 0 on entry; if it reaches TIMEOUT-1 with no memReady: memErr=1 next cycle, respPort=winner, no respValid/writeDone, rrPtr advances, go to IDLE.
REQ-027 memReady in the same cycle the counter hits TIMEOUT-1 SHALL count as completion, not timeout.
REQ-028 Minimum transaction spacing: IDLE->ISSUE->WAIT->IDLE; new grant no earlier than 3 cycles after the previous grant.
REQ-029 respData/respTag/respPort SHALL hold last values between pulses; respValid, writeDone, memErr are 0 otherwise.
REQ-030 A req bit that falls before grant SHALL receive no grant and no side effects.

Reset
REQ-031 reset SHALL force IDLE, rrPtr=0, counter=0, all outputs 0, in any state.
REQ-032 A memReady arriving after reset mid-transaction SHALL be ignored (no respValid/writeDone).

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum, port indices LOAD0=0, LOAD1=1, STORE=2, and widths DATA_W=16, TAG_W=4.
REQ-034 Sub-module rr_pick3 (combinational, 3 requests + 2-bit pointer -> one-hot winner + valid) SHALL implement selection.

Verification
REQ-035 req=3'b001, reqAddr0=16'h0040, reqTag0=2; memReady 3 cycles after memStart with memOut=16'hBEEF -> grant=001, memStart+memAddr=0040 once, respValid with respData=BEEF, respTag=2, respPort=0.
REQ-036 req=3'b111 held continuously, memory latency 1 -> grants in order 001,010,100,001, each spaced exactly 3 cycles.
REQ-037 Store req=3'b100, reqAddr2=16'h0010, reqWdata2=16'h1234 -> memWe=1, memWdata=1234, writeDone pulse, respValid stays 0.
REQ-038 TIMEOUT=4, memReady never asserted -> memErr pulse after 4 WAIT cycles, busy falls, next request granted normally.
REQ-039 reset asserted in WAIT, memReady two cycles later -> all outputs 0, no respValid, busy=0.
